// File: rtl/csp_channel.sv
// csp_channel: four-phase bundled-data CSP channel, sender/receiver FSMs around a DEPTH-entry FIFO.
// Define CSP_CHANNEL_PROBE_EN to expose the FIFO occupancy on count_o.
module csp_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_req_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ack_o,
    output logic             r_req_o,
    output logic [WIDTH-1:0] r_data_o,
    input  logic             r_ack_i
`ifdef CSP_CHANNEL_PROBE_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [0:0]       s_state_q, s_state_d;
    logic [1:0]       r_state_q, r_state_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             full, empty, push, pop, load;

    // Handshake decisions use the pre-edge occupancy, so a push into a full FIFO waits even if a pop happens.
    always_comb begin
        full      = count_q == CW'(DEPTH);
        empty     = count_q == '0;
        push      = (s_state_q == S_IDLE) && s_req_i && !full;
        pop       = (r_state_q == R_REQ) && r_ack_i;
        load      = (r_state_q == R_IDLE) && !empty && !r_ack_i;
        count_d   = count_q + CW'(push) - CW'(pop);
        s_state_d = (s_state_q == S_IDLE) ? (push ? S_ACK : S_IDLE) : (s_req_i ? S_ACK : S_IDLE);
        r_state_d = (r_state_q == R_IDLE) ? (load ? R_REQ : R_IDLE) :
                    (r_state_q == R_REQ)  ? (pop ? R_WAIT : R_REQ) :
                    (r_ack_i ? R_WAIT : R_IDLE);
        r_data_d  = load ? mem_q[rd_ptr_q] : r_data_q;
    end

    // Control state; reset drops every stored token and in-flight handshake at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_state_q <= S_IDLE;
            r_state_q <= R_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            r_data_q  <= '0;
        end else begin
            s_state_q <= s_state_d;
            r_state_q <= r_state_d;
            count_q   <= count_d;
            wr_ptr_q  <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q  <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            r_data_q  <= r_data_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data_i;
    end

    assign s_ack_o  = s_state_q == S_ACK;
    assign r_req_o  = r_state_q == R_REQ;
    assign r_data_o = r_data_q;
`ifdef CSP_CHANNEL_PROBE_EN
    assign count_o  = count_q;
`endif
endmodule

// File: tb/tb_csp_channel.sv
// tb_csp_channel: directed bench; three channels (WIDTH 8, 1, 33) share the handshake controls.
module tb_csp_channel;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_req, r_ack;
    logic [63:0] sd;
    logic        s_ack8, r_req8, s_ack1, r_req1, s_ack33, r_req33;
    logic [7:0]  rd8;
    logic [0:0]  rd1;
    logic [32:0] rd33;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef CSP_CHANNEL_PROBE_EN
    logic [1:0]  cnt8, cnt1, cnt33;
`endif

    always #5 clk = ~clk;

    csp_channel #(.WIDTH(8), .DEPTH(2)) u8 (
        .clk(clk), .rst_n(rst_n), .s_req_i(s_req), .s_data_i(sd[7:0]), .s_ack_o(s_ack8),
        .r_req_o(r_req8), .r_data_o(rd8), .r_ack_i(r_ack)
`ifdef CSP_CHANNEL_PROBE_EN
        , .count_o(cnt8)
`endif
    );
    csp_channel #(.WIDTH(1), .DEPTH(2)) u1 (
        .clk(clk), .rst_n(rst_n), .s_req_i(s_req), .s_data_i(sd[0:0]), .s_ack_o(s_ack1),
        .r_req_o(r_req1), .r_data_o(rd1), .r_ack_i(r_ack)
`ifdef CSP_CHANNEL_PROBE_EN
        , .count_o(cnt1)
`endif
    );
    csp_channel #(.WIDTH(33), .DEPTH(2)) u33 (
        .clk(clk), .rst_n(rst_n), .s_req_i(s_req), .s_data_i(sd[32:0]), .s_ack_o(s_ack33),
        .r_req_o(r_req33), .r_data_o(rd33), .r_ack_i(r_ack)
`ifdef CSP_CHANNEL_PROBE_EN
        , .count_o(cnt33)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input logic [1:0] e);
`ifdef CSP_CHANNEL_PROBE_EN
        chk("count8", cnt8, e);
        chk("count1", cnt1, e);
        chk("count33", cnt33, e);
`endif
    endtask

    task automatic wait_sack(input logic v);
        for (int i = 0; i < 40 && s_ack8 !== v; i++) @(negedge clk);
        if (s_ack8 !== v) chk("s_ack_timeout", s_ack8, v);
    endtask

    task automatic wait_rreq(input logic v);
        for (int i = 0; i < 40 && r_req8 !== v; i++) @(negedge clk);
        if (r_req8 !== v) chk("r_req_timeout", r_req8, v);
    endtask

    task automatic send(input logic [63:0] d);
        sd = d;
        s_req = 1'b1;
        @(negedge clk);
        wait_sack(1'b1);
        s_req = 1'b0;
        @(negedge clk);
        wait_sack(1'b0);
    endtask

    task automatic recv(input logic [63:0] e, input int dly);
        wait_rreq(1'b1);
        chk("r_data8", rd8, e[7:0]);
        chk("r_data1", rd1, e[0:0]);
        chk("r_data33", rd33, e[32:0]);
        chk("r_req_agree", {r_req1, r_req33}, 2'b11);
        repeat (dly) @(negedge clk);
        r_ack = 1'b1;
        @(negedge clk);
        wait_rreq(1'b0);
        r_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s_req = 1'b0;
        r_ack = 1'b0;
        sd    = '0;
        @(negedge clk);
        chk("rst_s_ack", s_ack8, 0);
        chk("rst_r_req", r_req8, 0);
        chk("rst_r_data8", rd8, 0);
        chk("rst_r_data33", rd33, 0);
        chk_cnt(2'd0);
        rst_n = 1'b1;

        sd    = 64'hA5;
        s_req = 1'b1;
        @(negedge clk);
        chk("push_ack", s_ack8, 1);
        chk("push_rreq", r_req8, 0);
        chk_cnt(2'd1);
        s_req = 1'b0;
        @(negedge clk);
        chk("fwd_rreq", r_req8, 1);
        chk("fwd_data", rd8, 8'hA5);
        chk("sack_drop", s_ack8, 0);
        r_ack = 1'b1;
        @(negedge clk);
        chk("pop_rreq", r_req8, 0);
        chk_cnt(2'd0);
        r_ack = 1'b0;
        @(negedge clk);

        send(64'h01);
        send(64'h02);
        chk_cnt(2'd2);
        chk("full_head_req", r_req8, 1);
        chk("full_head_data", rd8, 8'h01);
        sd    = 64'h03;
        s_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ack", s_ack8, 0);
        end
        r_ack = 1'b1;
        @(negedge clk);
        chk("stall_pop_rreq", r_req8, 0);
        chk("stall_same_edge_ack", s_ack8, 0);
        chk_cnt(2'd1);
        r_ack = 1'b0;
        @(negedge clk);
        chk("stall_accept", s_ack8, 1);
        chk_cnt(2'd2);
        s_req = 1'b0;
        @(negedge clk);
        recv(64'h02, 0);
        recv(64'h03, 0);
        chk_cnt(2'd0);

        send(64'h11);
        wait_rreq(1'b1);
        chk("simul_head", rd8, 8'h11);
        chk_cnt(2'd1);
        sd    = 64'h22;
        s_req = 1'b1;
        r_ack = 1'b1;
        @(negedge clk);
        chk("simul_ack", s_ack8, 1);
        chk("simul_rreq", r_req8, 0);
        chk_cnt(2'd1);
        s_req = 1'b0;
        r_ack = 1'b0;
        @(negedge clk);
        chk("simul_ack_drop", s_ack8, 0);
        recv(64'h22, 0);
        chk_cnt(2'd0);

        fork
            for (int i = 0; i < 25; i++) send(64'(i));
            for (int j = 0; j < 25; j++) recv(64'(j), int'($urandom_range(0, 3)));
        join
        chk_cnt(2'd0);

        send(64'h1_0000_0001);
        send(64'h0_FFFF_FFFE);
        recv(64'h1_0000_0001, 1);
        recv(64'h0_FFFF_FFFE, 2);

        send(64'h44);
        send(64'h55);
        chk_cnt(2'd2);
        chk("mid_rreq", r_req8, 1);
        chk("mid_data", rd8, 8'h44);
        sd    = 64'h66;
        s_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ack", s_ack8, 0);
        chk("arst_r_req", r_req8, 0);
        chk("arst_r_data8", rd8, 0);
        chk("arst_r_data33", rd33, 0);
        chk_cnt(2'd0);
        s_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h3C);
        recv(64'h3C, 0);
        chk_cnt(2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
